// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - registered instruction fetch port with byte-serial little-endian boot loader
// Optional parity protection is enabled with `define IMEM_PARITY_EN.
module imem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] instruction_addr_i,
  output logic [DATA_WIDTH-1:0]     instruction_rdata_o,
  input  logic                      load_start_i,
  input  logic [LEN_WIDTH-1:0]      load_words_i,
  input  logic                      load_valid_i,
  input  logic [7:0]                load_byte_i,
  output logic                      load_ready_o,
  output logic                      load_done_o,
  output logic                      core_rst_n_o,
  output logic                      fetch_err_o
);

  localparam int PTR_W = MEM_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << PTR_W;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    count_q, count_d;
  logic [LEN_WIDTH-1:0]    written_q, written_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-9:0]   asm_q, asm_d;
  logic                    core_rst_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_raw;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Words are stored XORed with NOP so an all-zero power-up image reads back as NOP.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  wire unused_addr_lsbs = &{1'b0, instruction_addr_i[1:0]};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    written_d    = written_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    wr_en        = 1'b0;
    wr_data      = {load_byte_i, asm_q};
    load_ready_o = 1'b0;
    load_done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          count_d    = load_words_i;
          written_d  = '0;
          ptr_d      = '0;
          byte_cnt_d = '0;
          state_d    = (load_words_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          if (byte_cnt_q == 2'd3) begin
            wr_en      = 1'b1;
            ptr_d      = ptr_q + PTR_W'(1);
            written_d  = written_q + LEN_WIDTH'(1);
            byte_cnt_d = '0;
            if (written_d == count_q) state_d = S_DONE;
          end else begin
            asm_d[8*byte_cnt_q +: 8] = load_byte_i;
            byte_cnt_d               = byte_cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        load_done_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      written_q  <= '0;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      written_q  <= written_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      core_rst_q <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= wr_data ^ NOP;
  end

  assign rd_raw  = mem_q[instruction_addr_i[MEM_ADDR_WIDTH-1:2]];
  assign rd_word = rd_raw ^ NOP;

`ifdef IMEM_PARITY_EN
  // Parity covers the stored (NOP-XORed) image, so zero-initialised bits are consistent.
  logic             par_q [DEPTH];
  logic             err_q;
  logic             par_bad;

  assign par_bad = (state_q == S_IDLE) && ((^rd_raw) != par_q[instruction_addr_i[MEM_ADDR_WIDTH-1:2]]);

  always_ff @(posedge clk) begin
    if (wr_en) par_q[ptr_q] <= ^(wr_data ^ NOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= NOP;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= (state_q != S_IDLE || par_bad) ? NOP : rd_word;
      err_q   <= err_q | par_bad;
    end
  end

  assign fetch_err_o = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= NOP;
    else        rdata_q <= (state_q != S_IDLE) ? NOP : rd_word;
  end

  assign fetch_err_o = 1'b0;
`endif

  assign instruction_rdata_o = rdata_q;
  assign core_rst_n_o        = core_rst_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder fetch and boot-load behaviour
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  instruction_addr_i;
  logic [31:0] instruction_rdata_o;
  logic        load_start_i;
  logic [15:0] load_words_i;
  logic        load_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic        core_rst_n_o;
  logic        fetch_err_o;

  imem_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_addr_i  (instruction_addr_i),
    .instruction_rdata_o (instruction_rdata_o),
    .load_start_i        (load_start_i),
    .load_words_i        (load_words_i),
    .load_valid_i        (load_valid_i),
    .load_byte_i         (load_byte_i),
    .load_ready_o        (load_ready_o),
    .load_done_o         (load_done_o),
    .core_rst_n_o        (core_rst_n_o),
    .fetch_err_o         (fetch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire expected fetch data on its due cycle, and watch loader outputs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc || instruction_rdata_o !== e.data) begin
        errors++;
        $display("FAIL %s: rdata got %h want %h (cycle %0d due %0d)", e.name, instruction_rdata_o, e.data, cyc, e.due);
      end
    end
    if (load_ready_o) begin
      checks++;
      if (core_rst_n_o !== 1'b0) begin
        errors++;
        $display("FAIL core_rst_in_load: got %b want 0", core_rst_n_o);
      end
    end
    if (load_done_o) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic fetch(input logic [9:0] a, input logic [31:0] want, input string name);
    instruction_addr_i = a;
    q.push_back('{cyc + 1, want, name});
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [15:0] n);
    load_start_i = 1'b1;
    load_words_i = n;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    load_valid_i = 1'b1;
    load_byte_i  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (load_ready_o) ok = 1;
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got ready=0 want ready=1 for byte %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (load_done_o) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_core_rst_at_done"}, 32'(core_rst_n_o), 32'd0);
    exp_done++;
    @(negedge clk);
    chk({name, "_core_rst_after"}, 32'(core_rst_n_o), 32'd1);
    chk({name, "_done_single"}, 32'(load_done_o), 32'd0);
    chk({name, "_done_count"}, done_cnt, exp_done);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    instruction_addr_i = '0;
    load_start_i = 1'b0;
    load_words_i = '0;
    load_valid_i = 1'b0;
    load_byte_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", instruction_rdata_o, NOP);
    chk("rst_ready", 32'(load_ready_o), 32'd0);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_err", 32'(fetch_err_o), 32'd0);
    chk("rst_core", 32'(core_rst_n_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(10'h000, NOP, "fetch_after_reset");
    @(negedge clk);
    chk("core_rst_after_release", 32'(core_rst_n_o), 32'd1);
    @(posedge clk); #1;

    start(16'd2);
    fetch(10'h000, NOP, "fetch_during_load");
    send_word(32'h0010_0513);
    send_word(32'h0020_0093);
    wait_done("load2");
    fetch(10'h000, 32'h0010_0513, "fetch_w0");
    fetch(10'h004, 32'h0020_0093, "fetch_w1");
    fetch(10'h006, 32'h0020_0093, "fetch_unaligned");
    fetch(10'h008, NOP, "fetch_unwritten");

    start(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("stall_ready", 32'(load_ready_o), 32'd1);
    chk("stall_no_done", done_cnt, exp_done);
    @(posedge clk); #1;
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_done("stall");
    fetch(10'h000, 32'hDDCC_BBAA, "fetch_after_stall");
    fetch(10'h004, 32'h0020_0093, "fetch_w1_kept");

    start(16'd2);
    send_word(32'h4433_2211);
    send_byte(8'h55);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(load_ready_o), 32'd0);
    chk("midrst_core", 32'(core_rst_n_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(10'h000, 32'h4433_2211, "midrst_w0_new");
    fetch(10'h004, 32'h0020_0093, "midrst_w1_kept");
    chk("midrst_done_count", done_cnt, exp_done);

    start(16'd0);
    wait_done("zero_len");
    fetch(10'h000, 32'h4433_2211, "zero_len_w0_kept");

    start(16'd257);
    for (int i = 0; i < 257; i++) send_word(32'h1000_0000 + 32'(i));
    wait_done("wrap");
    fetch(10'h000, 32'h1000_0100, "wrap_w0_overwritten");
    fetch(10'h004, 32'h1000_0001, "wrap_w1");
    fetch(10'h3FC, 32'h1000_00FF, "wrap_last");
    fetch(10'h3FE, 32'h1000_00FF, "wrap_last_unaligned");
    chk("err_flag", 32'(fetch_err_o), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
